// File: rtl/pipe_interlock_gen_if.sv
// Bus bundle between the pipeline interlock controller and the datapath.
// The master side (datapath / hazard units) raises stall and flush requests
// and the global wait; the slave side (pipe_interlock_gen) returns per-stage
// hold, bubble, kill and valid controls plus stall status and the watchdog flag.
//   nWAIT         global clock enable, low freezes the controller
//   stall_req     per-source stall request
//   stall_stage   packed per-source stage index, field i = [i*SW +: SW]
//   flush_req     kill stages 0..flush_stage
//   flush_stage   highest killed stage (clamped to STAGES-1)
//   en_bar        per-stage active-low register enable (1 = hold)
//   bubble        stage loads a bubble at the next edge
//   kill          stage must not commit side effects this cycle
//   valid         stage holds a real instruction
//   stall_active  an effective stall exists
//   stall_top     effective stall stage (0 when idle)
//   stall_timeout watchdog fired
interface pipe_interlock_gen_if #(
  parameter int STAGES = 5,
  parameter int NSRC   = 4,
  parameter int SW     = 3
);
  logic                 nWAIT;
  logic [NSRC-1:0]      stall_req;
  logic [NSRC*SW-1:0]   stall_stage;
  logic                 flush_req;
  logic [SW-1:0]        flush_stage;
  logic [STAGES-1:0]    en_bar;
  logic [STAGES-1:0]    bubble;
  logic [STAGES-1:0]    kill;
  logic [STAGES-1:0]    valid;
  logic                 stall_active;
  logic [SW-1:0]        stall_top;
  logic                 stall_timeout;

  modport master (
    output nWAIT, stall_req, stall_stage, flush_req, flush_stage,
    input  en_bar, bubble, kill, valid, stall_active, stall_top, stall_timeout
  );

  modport slave (
    input  nWAIT, stall_req, stall_stage, flush_req, flush_stage,
    output en_bar, bubble, kill, valid, stall_active, stall_top, stall_timeout
  );
endinterface

// File: rtl/pipe_interlock_gen.sv
// Pipeline interlock controller for an in-order core (stage 0 = fetch,
// stage STAGES-1 = writeback). Tracks a valid bit per stage so refill after a
// flush happens on its own, arbitrates vectorised stall requests (oldest stage
// wins), applies a single flush port with priority over stalls at or below the
// flush point, and runs a watchdog over consecutive stalled cycles.
// Ports:
//   nGCLK   clock, all state changes on posedge
//   nRESET  asynchronous active-low reset
//   bus     pipe_interlock_gen_if slave modport (requests in, controls out)
// Hold/bubble/kill/stall status are combinational from the inputs and valid.
module pipe_interlock_gen #(
  parameter int STAGES  = 5,
  parameter int NSRC    = 4,
  parameter int SW      = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                 nGCLK,
  input  logic                 nRESET,
  pipe_interlock_gen_if.slave  bus
);
  localparam int CW   = $clog2(TIMEOUT + 1);
  localparam int SPAN = 1 << SW;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  logic [STAGES-1:0] valid_r;
  logic [STAGES-1:0] valid_nxt_s;
  logic [STAGES-1:0] en_bar_s;
  logic [STAGES-1:0] bubble_s;
  logic [STAGES-1:0] kill_s;
  logic [STAGES-1:0] flush_mask_s;
  logic [STAGES-1:0] hold_mask_s;
  logic [SPAN-1:0]   valid_ext_s;
  logic [SW-1:0]     flush_top_s;
  logic [SW-1:0]     stall_top_s;
  logic              stall_act_s;
  logic [CW-1:0]     cnt_r;

  // Clamp an out-of-range flush stage to the last stage
  always_comb begin
    flush_top_s = (int'(bus.flush_stage) >= STAGES) ? SW'(STAGES - 1) : bus.flush_stage;
  end

  // Stall arbiter: drop requests from bubbles, out-of-range stages and killed
  // stages, then pick the highest (oldest) remaining stage
  always_comb begin
    logic [SW-1:0] st;
    logic          eff;
    st          = '0;
    eff         = 1'b0;
    stall_act_s = 1'b0;
    stall_top_s = '0;
    // Widened copy so any SW-bit index is in range; out-of-range stages read 0
    valid_ext_s = '0;
    valid_ext_s[STAGES-1:0] = valid_r;
    for (int i = 0; i < NSRC; i++) begin
      st  = bus.stall_stage[i*SW +: SW];
      eff = bus.stall_req[i] && (int'(st) < STAGES) && valid_ext_s[st] &&
            !(bus.flush_req && (st <= flush_top_s));
      stall_top_s = (eff && (st > stall_top_s)) ? st : stall_top_s;
      stall_act_s = stall_act_s | eff;
    end
  end

  // Per-stage hold, bubble, kill and next-valid decode
  always_comb begin
    flush_mask_s = '0;
    hold_mask_s  = '0;
    en_bar_s     = '0;
    bubble_s     = '0;
    kill_s       = '0;
    valid_nxt_s  = '0;
    for (int k = 0; k < STAGES; k++) begin
      flush_mask_s[k] = bus.flush_req && (k <= int'(flush_top_s));
      hold_mask_s[k]  = stall_act_s && (k <= int'(stall_top_s));
      kill_s[k]       = ~valid_r[k] | flush_mask_s[k];
      en_bar_s[k]     = ~bus.nWAIT | hold_mask_s[k];
    end
    // Stage 0 fetches whenever it is not held; that covers the redirect target
    valid_nxt_s[0] = en_bar_s[0] ? (valid_r[0] & ~flush_mask_s[0]) : 1'b1;
    for (int k = 1; k < STAGES; k++) begin
      // A bubble enters behind a killed stage that is not itself held, and
      // directly above the stalled stage so its instruction is not duplicated
      bubble_s[k] = bus.nWAIT &&
                    ((flush_mask_s[k-1] && !hold_mask_s[k]) ||
                     (stall_act_s && (k == int'(stall_top_s) + 1)));
      valid_nxt_s[k] = hold_mask_s[k] ? (valid_r[k] & ~flush_mask_s[k]) :
                       (bubble_s[k] ? 1'b0 : valid_r[k-1]);
    end
  end

  // Valid pipeline and stall watchdog; everything freezes while nWAIT is low
  always_ff @(posedge nGCLK or negedge nRESET) begin
    if (!nRESET) begin
      valid_r <= '0;
      cnt_r   <= '0;
    end else if (bus.nWAIT) begin
      valid_r <= valid_nxt_s;
      if (!stall_act_s) begin
        cnt_r <= '0;
      end else if (cnt_r != CNT_MAX) begin
        cnt_r <= cnt_r + CW'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end else begin
      valid_r <= valid_r;
      cnt_r   <= cnt_r;
    end
  end

  assign bus.en_bar        = en_bar_s;
  assign bus.bubble        = bubble_s;
  assign bus.kill          = kill_s;
  assign bus.valid         = valid_r;
  assign bus.stall_active  = stall_act_s;
  assign bus.stall_top     = stall_top_s;
  assign bus.stall_timeout = (cnt_r == CNT_MAX);
endmodule
